// File: rtl/mem_bridge_if.sv
// CPU-side and physical-memory-side signal bundle for mem_bridge.
// slave = the bridge itself; master = the CPU / memory environment.
interface mem_bridge_if;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 2;

  logic [AW-1:0] mem_address;
  logic          mem_read;
  logic          mem_write;
  logic [BW-1:0] mem_byte_enable;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_resp;
  logic          mem_err;

  logic [AW-1:0] pmem_address;
  logic          pmem_read;
  logic          pmem_write;
  logic [BW-1:0] pmem_wmask;
  logic [DW-1:0] pmem_wdata;
  logic [DW-1:0] pmem_rdata;
  logic          pmem_resp;

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp, mem_err,
    output pmem_address, pmem_read, pmem_write, pmem_wmask, pmem_wdata
  );

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp, mem_err,
    input  pmem_address, pmem_read, pmem_write, pmem_wmask, pmem_wdata
  );
endinterface

// File: rtl/mem_bridge.sv
// Single-outstanding CPU-to-physical-memory bridge with response timeout
// and a sticky error flag; every output comes straight from a register.
module mem_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_bridge_if.slave  bus
);
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 2;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [BW-1:0] wmask;
    logic [DW-1:0] wdata;
    logic          op_wr;
  } req_t;

  state_t        r_state, w_state_nxt;
  req_t          r_req, w_req_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [DW-1:0] r_rdata, w_rdata_nxt;
  logic          r_pread, w_pread_nxt;
  logic          r_pwrite, w_pwrite_nxt;
  logic          r_resp, w_resp_nxt;
  logic          r_err, w_err_nxt;

  assign w_cnt_inc = r_cnt + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_req    <= '0;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_pread  <= 1'b0;
      r_pwrite <= 1'b0;
      r_resp   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_req    <= w_req_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rdata  <= w_rdata_nxt;
      r_pread  <= w_pread_nxt;
      r_pwrite <= w_pwrite_nxt;
      r_resp   <= w_resp_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // Next state plus next values of the registered outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_req_nxt    = r_req;
    w_cnt_nxt    = r_cnt;
    w_rdata_nxt  = r_rdata;
    w_err_nxt    = r_err;
    w_pread_nxt  = 1'b0;
    w_pwrite_nxt = 1'b0;
    w_resp_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          // A simultaneous read+write is a write.
          w_req_nxt.addr  = bus.mem_address;
          w_req_nxt.wmask = bus.mem_byte_enable;
          w_req_nxt.wdata = bus.mem_wdata;
          w_req_nxt.op_wr = bus.mem_write;
          w_cnt_nxt       = '0;
          w_pread_nxt     = !bus.mem_write;
          w_pwrite_nxt    = bus.mem_write;
          w_state_nxt     = BUSY;
        end
      end
      BUSY: begin
        if (bus.pmem_resp) begin
          if (!r_req.op_wr) w_rdata_nxt = bus.pmem_rdata;
          w_resp_nxt  = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == CW'(TIMEOUT)) begin
            w_rdata_nxt = '0;
            w_err_nxt   = 1'b1;
            w_resp_nxt  = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_pread_nxt  = r_pread;
            w_pwrite_nxt = r_pwrite;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.pmem_address = r_req.addr;
  assign bus.pmem_wmask   = r_req.wmask;
  assign bus.pmem_wdata   = r_req.wdata;
  assign bus.pmem_read    = r_pread;
  assign bus.pmem_write   = r_pwrite;
  assign bus.mem_rdata    = r_rdata;
  assign bus.mem_resp     = r_resp;
  assign bus.mem_err      = r_err;
endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum BUSY cycles without pmem_resp before the transfer is aborted (range 1..255).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 mem_address  in  16  CPU word/byte address.
REQ-005 mem_read, mem_write  in  1 each  CPU request levels, held by the CPU until mem_resp.
REQ-006 mem_byte_enable  in  2  CPU lane mask: bit0 low byte, bit1 high byte.
REQ-007 mem_wdata  in  16  CPU store data.
REQ-008 mem_rdata  out  16  read data, valid only while mem_resp=1.
REQ-009 mem_resp  out  1  one-cycle completion pulse to CPU.
REQ-010 pmem_address  out  16  latched address to physical memory.
REQ-011 pmem_read, pmem_write  out  1 each  physical request levels.
REQ-012 pmem_wmask  out  2  latched lane mask.
REQ-013 pmem_wdata  out  16  latched store data.
REQ-014 pmem_rdata  in  16  physical read data, valid with pmem_resp.
REQ-015 pmem_resp  in  1  physical completion, any latency >= 0 cycles after request.
REQ-016 mem_err  out  1  sticky timeout flag.

Function
REQ-017 FSM states SHALL be IDLE, BUSY, DONE; all outputs SHALL be driven from registered state and registered request fields.
REQ-018 IDLE: on a rising edge with mem_read|mem_write=1, SHALL latch address, byte_enable, wdata, and the op (write if mem_write=1, else read), clear the timeout counter, and go to BUSY.
REQ-019 mem_read=1 and mem_write=1 together SHALL be treated as a write; the read is dropped.
REQ-020 BUSY: exactly one of pmem_read/pmem_write SHALL be 1, matching the latched op; pmem_address/pmem_wmask/pmem_wdata SHALL hold the latched values and SHALL NOT track CPU inputs.
REQ-021 BUSY with pmem_resp=1 on an edge: SHALL capture pmem_rdata (reads only) into the read-data register and go to DONE.
REQ-022 BUSY with pmem_resp=0: the counter SHALL increment; when it equals TIMEOUT, the block SHALL go to DONE, load the read-data register with 16'h0000, and set mem_err=1.
REQ-023 pmem_resp=1 in the same cycle the counter reaches TIMEOUT: the response SHALL win; normal completion, mem_err unchanged.
REQ-024 DONE: mem_resp=1 for exactly one cycle; mem_rdata = read-data register; pmem_read=pmem_write=0; next state IDLE unconditionally.
REQ-025 Outside DONE, mem_resp=0 and mem_rdata SHALL hold its last value.
REQ-026 The block SHALL NOT accept a new request in the DONE cycle; a CPU request still high in DONE is re-sampled in IDLE on the following edge.
REQ-027 Minimum latency: request first high in cycle 0; pmem request in cycle 1; pmem_resp in cycle 1; mem_resp in cycle 2. Each cycle of pmem wait adds one cycle.
REQ-028 Write completions SHALL NOT modify the read-data register.
REQ-029 mem_err SHALL remain 1 until reset; later transfers SHALL proceed normally.

Reset
REQ-030 While rst_n=0: state=IDLE; counter=0; mem_resp, pmem_read, pmem_write, mem_err=0; pmem_address, pmem_wdata, mem_rdata=16'h0000; pmem_wmask=2'b00.
REQ-031 A reset asserted in BUSY or DONE SHALL drop pmem_read/pmem_write immediately (asynchronous). No mem_resp SHALL be issued for the aborted transfer.
REQ-032 After rst_n rises, the first edge SHALL evaluate IDLE; a held CPU request SHALL be accepted on that edge.

Verification
REQ-033 Read, zero-wait: mem_read=1, addr=16'h1234, pmem_resp=1 in cycle 1 with pmem_rdata=16'hBEEF -> pmem_read=1 in cycle 1 only; mem_resp=1 with mem_rdata=16'hBEEF in cycle 2.
REQ-034 Byte store: mem_write=1, byte_enable=2'b01, wdata=16'h00A5, pmem_resp delayed 3 cycles -> pmem_write held 4 cycles with wmask=2'b01 and wdata=16'h00A5; single mem_resp pulse; mem_rdata unchanged.
REQ-035 Input change while BUSY: change mem_address after acceptance -> pmem_address keeps the original value until DONE.
REQ-036 Timeout: TIMEOUT=4, pmem_resp never asserted -> mem_resp in the cycle after the 4th BUSY cycle, mem_rdata=16'h0000, mem_err=1 and sticky; a next read then completes normally.
REQ-037 Timeout tie: pmem_resp=1 in the same cycle the counter reaches TIMEOUT, pmem_rdata=16'h5A5A -> mem_rdata=16'h5A5A and mem_err=0.
REQ-038 Reset mid-transfer: rst_n=0 while BUSY -> pmem_read=0 in the same cycle and no mem_resp. Release reset with mem_read held -> new transfer accepted on the first edge.
